alu_mod_sequencer: RTL and testbench

//  Multi-cycle controller that implements the ALU MOD operation (alu_op 111) by

---
 rtl/alu_mod_sequencer_pkg.sv | 28 ++
 rtl/alu_mod_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_mod_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_mod_sequencer_pkg.sv
// Shared ALU opcodes, FSM state encoding and status flag bundle for the MOD sequencer.
package alu_mod_sequencer_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_MOD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SUB   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic div_zero;
    logic invalid;
    logic timeout;
  } mod_flags_t;

endpackage

// File: rtl/alu_mod_sequencer.sv
// Multi-cycle MOD controller: drives the shared ALU through SLT/SUB passes until
// the remainder drops below the divisor, with divide-by-zero, sign and timeout aborts.
module alu_mod_sequencer
  import alu_mod_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                div_zero,
  output logic                invalid,
  output logic                timeout
);

  localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      r_q, r_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0]      alu_a_q, alu_a_d;
  logic [WIDTH-1:0]      alu_b_q, alu_b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      result_q, result_d;
  mod_flags_t            flags_q, flags_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      b_q      <= '0;
      iter_q   <= '0;
      alu_op_q <= ALU_AND;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      iter_q   <= iter_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Next state, datapath updates, and the outputs that belong to the next state
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    b_d      = b_q;
    iter_d   = iter_q;
    result_d = result_q;
    flags_d  = flags_q;
    alu_op_d = ALU_AND;
    alu_a_d  = '0;
    alu_b_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          flags_d = '0;
          b_d     = b;
          r_d     = a;
          iter_d  = '0;
          if (b == '0) begin
            flags_d.div_zero = 1'b1;
            result_d         = a;
            state_d          = ST_DONE;
          end else if (a[WIDTH-1] || b[WIDTH-1]) begin
            flags_d.invalid = 1'b1;
            result_d        = '0;
            state_d         = ST_DONE;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (alu_result[0]) begin
          result_d = r_q;
          state_d  = ST_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          flags_d.timeout = 1'b1;
          result_d        = r_q;
          state_d         = ST_DONE;
        end else begin
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        r_d     = alu_result;
        iter_d  = iter_q + ITER_W'(1);
        state_d = ST_CHECK;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // ALU controls are registered, so they are derived from the state being entered
    unique case (state_d)
      ST_CHECK: begin
        alu_op_d = ALU_SLT;
        alu_a_d  = r_d;
        alu_b_d  = b_d;
      end
      ST_SUB: begin
        alu_op_d = ALU_SUB;
        alu_a_d  = r_d;
        alu_b_d  = b_d;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = flags_q.div_zero;
  assign invalid  = flags_q.invalid;
  assign timeout  = flags_q.timeout;

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Self-checking bench: MOD sequencer paired with a behavioural 32-bit ALU, checked
// against an arithmetic reference model of the modulo, error and timeout rules.
module tb_alu_mod_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned MI = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic [W-1:0]  alu_result;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          div_zero, invalid, timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_mod_sequencer #(.WIDTH(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .alu_result(alu_result), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .result(result),
    .div_zero(div_zero), .invalid(invalid), .timeout(timeout)
  );

  // Behavioural 32-bit ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a ^ alu_b;
      3'b011:  alu_result = ~(alu_a | alu_b);
      3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b101:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: result/flags/latency straight from the arithmetic definition
  task automatic ref_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] res, output logic dz, output logic inv,
                         output logic to, output int lat);
    longint sx, sy, q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0; inv = 1'b0; to = 1'b0;
    if (y == 0) begin
      dz = 1'b1; res = x; lat = 1;
    end else if (sx < 0 || sy < 0) begin
      inv = 1'b1; res = '0; lat = 1;
    end else begin
      q = sx / sy;
      if (q <= longint'(MI)) begin
        res = W'(sx % sy);
        lat = 2 * int'(q) + 2;
      end else begin
        to  = 1'b1;
        res = W'(sx - longint'(MI) * sy);
        lat = 2 * int'(MI) + 2;
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input bit hold_start, input bit scramble);
    logic [W-1:0] e_res;
    logic e_dz, e_inv, e_to;
    int e_lat, lat;
    logic [W-1:0] r_exp;
    ref_mod(ta, tb, e_res, e_dz, e_inv, e_to, e_lat);
    a = ta; b = tb; start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      if (scramble) begin a = $urandom; b = $urandom; end
      @(negedge clk);
      if (done) begin lat = n; break; end
      r_exp = ta - W'((n - 1) / 2) * tb;
      chk("alu_op", 32'(alu_op), (n % 2 == 1) ? 32'd4 : 32'd6);
      chk("alu_a", alu_a, r_exp);
      chk("alu_b", alu_b, tb);
      chk("busy", 32'(busy), 32'd1);
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("result", result, e_res);
    chk("div_zero", 32'(div_zero), 32'(e_dz));
    chk("invalid", 32'(invalid), 32'(e_inv));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("done_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("result_held", result, e_res);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int guard;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(32'd17, 32'd5, 1'b0, 1'b0);
    run_op(32'd3, 32'd7, 1'b0, 1'b0);
    run_op(32'd0, 32'd9, 1'b0, 1'b0);
    run_op(32'd42, 32'd0, 1'b0, 1'b0);
    run_op(-32'sd8, 32'd3, 1'b0, 1'b0);
    run_op(32'd100, 32'd1, 1'b0, 1'b0);
    run_op(32'd23, 32'd4, 1'b1, 1'b1);
    run_op(32'd48, 32'd3, 1'b0, 1'b0);

    // Reset in the middle of a SUB pass
    a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (alu_op != 3'b110 && guard < 10);
    chk("reach_sub", 32'(alu_op), 32'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {29'd0, div_zero, invalid, timeout}, 32'd0);
    @(negedge clk);
    chk("midrst_done", 32'(done), 32'd0);
    run_op(32'd10, 32'd4, 1'b0, 1'b0);

    // Randomized operands, including zero and negative divisors/dividends
    for (int i = 0; i < 24; i++) begin
      rb = W'($urandom_range(0, 40));
      ra = W'($urandom_range(0, 700));
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = -ra - 32'd1;
      if ($urandom_range(0, 9) == 0) rb = -rb - 32'd1;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
